// File: rtl/fb_port_arbiter_if.sv
// Bundles the VGA read, camera write, frame-buffer RAM and status signals of the port arbiter.
// The arbiter binds to the slave modport; the surrounding capture/display/BRAM logic binds to master.
interface fb_port_arbiter_if #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int STARVE_W   = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [LVL_W-1:0]    fifo_level;
    logic [STARVE_W-1:0] starve_cnt;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output fifo_level, starve_cnt
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  fifo_level, starve_cnt
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA reads win every cycle (1-cycle read latency), camera writes queue in a FIFO
// and drain on read-free cycles; wr_ready drops only when the FIFO is full, never on a same-cycle pop.
module fb_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int STARVE_W   = 16
) (
    input  logic             pixel_clk,
    input  logic             rst,
    fb_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                rd_valid_q, rd_valid_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    always_comb begin
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        fifo_empty = (level_q == '0);
        push       = bus.wr_valid && !fifo_full;
        // Reset also blocks the RAM port so a queued write cannot slip out while being discarded.
        pop        = !rst && !bus.rd_req && !fifo_empty;

        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            if (bus.rd_req) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.rd_addr;
            end else if (!fifo_empty) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = fifo_addr_q[rd_ptr_q];
                bus.mem_wdata = fifo_data_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rd_valid_d = bus.rd_req;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        starve_d = starve_q;
        if (bus.rd_req && !fifo_empty && (starve_q != '1)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            starve_q   <= starve_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been pushed.
    always_ff @(posedge pixel_clk) begin
        if (push && !rst) begin
            fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
            fifo_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready   = !fifo_full;
    assign bus.fifo_level = level_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_valid_q ? bus.mem_rdata : '0;
    assign bus.starve_cnt = starve_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM, scoreboard queues for reads and writes, one task per scenario.
module tb_fb_port_arbiter;
    localparam int AW = 19;
    localparam int DW = 12;
    localparam int D  = 16;

    logic pixel_clk = 1'b0;
    logic rst;
    logic rst2;

    always #20 pixel_clk = ~pixel_clk;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .STARVE_W(16)) bus ();
    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .STARVE_W(4))  bus2 ();

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .STARVE_W(16)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .bus(bus)
    );
    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .STARVE_W(4)) dut2 (
        .pixel_clk(pixel_clk), .rst(rst2), .bus(bus2)
    );

    assign bus2.mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [int];

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return '0;
    endfunction

    always @(posedge pixel_clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
            else            bus.mem_rdata <= ram_rd(bus.mem_addr);
        end
    end

    // Reference model and scoreboard: expected writes queued on accept, expected reads queued on request.
    logic [AW+DW-1:0] wq [$];
    logic [DW-1:0]    rq [$];
    int               lvl_m = 0;
    logic             vld_m = 1'b0;
    logic [15:0]      st_m  = '0;

    always @(negedge pixel_clk) begin
        logic push_m, pop_m, en_m, we_m;
        en_m = !rst && (bus.rd_req || lvl_m != 0);
        we_m = !rst && !bus.rd_req && lvl_m != 0;
        if (mon_en) begin
            n_chk++;
            if (bus.fifo_level !== 5'(lvl_m)) begin
                n_fail++; $display("FAIL mon_level t=%0t got %0d exp %0d", $time, bus.fifo_level, lvl_m);
            end
            n_chk++;
            if (bus.wr_ready !== (lvl_m != D)) begin
                n_fail++; $display("FAIL mon_wr_ready t=%0t got %b exp %b", $time, bus.wr_ready, lvl_m != D);
            end
            n_chk++;
            if (bus.starve_cnt !== st_m) begin
                n_fail++; $display("FAIL mon_starve t=%0t got %0d exp %0d", $time, bus.starve_cnt, st_m);
            end
            n_chk++;
            if (bus.rd_valid !== vld_m) begin
                n_fail++; $display("FAIL mon_rd_valid t=%0t got %b exp %b", $time, bus.rd_valid, vld_m);
            end
            n_chk++;
            if (vld_m) begin
                if (rq.size() == 0 || bus.rd_data !== rq[0]) begin
                    n_fail++; $display("FAIL mon_rd_data t=%0t got %h exp %h", $time, bus.rd_data,
                                       (rq.size() != 0) ? rq[0] : 12'h000);
                end
            end else if (bus.rd_data !== '0) begin
                n_fail++; $display("FAIL mon_rd_data_idle t=%0t got %h exp 000", $time, bus.rd_data);
            end
            n_chk++;
            if (bus.mem_en !== en_m || bus.mem_we !== we_m) begin
                n_fail++; $display("FAIL mon_mem_ctl t=%0t got en=%b we=%b exp en=%b we=%b",
                                   $time, bus.mem_en, bus.mem_we, en_m, we_m);
            end
            if (en_m && !we_m) begin
                n_chk++;
                if (bus.mem_addr !== bus.rd_addr) begin
                    n_fail++; $display("FAIL mon_rd_addr t=%0t got %h exp %h", $time, bus.mem_addr, bus.rd_addr);
                end
            end
            if (we_m) begin
                n_chk++;
                if (wq.size() == 0 || {bus.mem_addr, bus.mem_wdata} !== wq[0]) begin
                    n_fail++; $display("FAIL mon_wr_order t=%0t got %h/%h exp %h", $time, bus.mem_addr,
                                       bus.mem_wdata, (wq.size() != 0) ? wq[0] : '0);
                end
            end
        end
        if (rst) begin
            lvl_m = 0; st_m = '0; vld_m = 1'b0;
            wq.delete(); rq.delete();
        end else begin
            push_m = bus.wr_valid && (lvl_m != D);
            pop_m  = !bus.rd_req && (lvl_m != 0);
            if (bus.rd_req && lvl_m != 0 && st_m != 16'hFFFF) st_m++;
            if (pop_m && wq.size() != 0) void'(wq.pop_front());
            if (push_m) wq.push_back({bus.wr_addr, bus.wr_data});
            if (push_m && !pop_m) lvl_m++;
            else if (!push_m && pop_m) lvl_m--;
            if (vld_m && rq.size() != 0) void'(rq.pop_front());
            vld_m = bus.rd_req;
            if (bus.rd_req) rq.push_back(ram_rd(bus.rd_addr));
        end
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        @(negedge pixel_clk);
        n_chk++;
        if (bus.fifo_level !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.starve_cnt !== '0) begin
            n_fail++; $display("FAIL reset_state got lvl=%0d vld=%b data=%h st=%0d exp all 0",
                               bus.fifo_level, bus.rd_valid, bus.rd_data, bus.starve_cnt);
        end
        n_chk++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h exp all 0",
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        n_chk++;
        if (bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready);
        end
        tick();
    endtask

    task automatic test_read_stream();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus.rd_req  = (c < 10);
            bus.rd_addr = AW'(c);
            @(negedge pixel_clk);
            n_chk++;
            if (c >= 1 && c <= 10) begin
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(12'h100 + c - 1)) begin
                    n_fail++; $display("FAIL read_stream c=%0d got vld=%b data=%h exp vld=1 data=%h",
                                       c, bus.rd_valid, bus.rd_data, 12'h100 + c - 1);
                end
            end else if (bus.rd_valid !== 1'b0) begin
                n_fail++; $display("FAIL read_stream_idle c=%0d got vld=%b exp 0", c, bus.rd_valid);
            end
            n_chk++;
            if (bus.mem_we !== 1'b0) begin
                n_fail++; $display("FAIL read_stream_we c=%0d got %b exp 0", c, bus.mem_we);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_only();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.wr_valid = (c < 5);
            bus.wr_addr  = AW'(20 + c);
            bus.wr_data  = DW'(12'h0A0 + c);
            @(negedge pixel_clk);
            n_chk++;
            if (c >= 1 && c <= 5) begin
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(20 + c - 1) || bus.mem_wdata !== DW'(12'h0A0 + c - 1)) begin
                    n_fail++; $display("FAIL write_only c=%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                                       c, bus.mem_we, bus.mem_addr, bus.mem_wdata, 20 + c - 1, 12'h0A0 + c - 1);
                end
            end else if (bus.mem_we !== 1'b0) begin
                n_fail++; $display("FAIL write_only_idle c=%0d got we=%b exp 0", c, bus.mem_we);
            end
            tick();
        end
        idle_inputs();
        @(negedge pixel_clk);
        n_chk++;
        if (bus.fifo_level !== '0 || ram_rd(AW'(22)) !== 12'h0A2) begin
            n_fail++; $display("FAIL write_only_end got lvl=%0d ram22=%h exp lvl=0 ram22=0a2",
                               bus.fifo_level, ram_rd(AW'(22)));
        end
        tick();
    endtask

    task automatic test_contention();
        int acc = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            bus.rd_req   = (c < 30);
            bus.rd_addr  = AW'(c);
            bus.wr_valid = (acc < 20);
            bus.wr_addr  = AW'(200 + acc);
            bus.wr_data  = DW'(12'h300 + acc);
            @(negedge pixel_clk);
            if (c == 30) begin
                n_chk++;
                if (bus.fifo_level !== 5'd16 || bus.starve_cnt !== 16'd29 || bus.wr_ready !== 1'b0 || acc != 16) begin
                    n_fail++; $display("FAIL contention_peak got lvl=%0d st=%0d rdy=%b acc=%0d exp 16/29/0/16",
                                       bus.fifo_level, bus.starve_cnt, bus.wr_ready, acc);
                end
            end
            if (bus.wr_valid && bus.wr_ready) acc++;
            tick();
        end
        idle_inputs();
        @(negedge pixel_clk);
        n_chk++;
        if (acc != 20 || bus.fifo_level !== '0 || bus.wr_ready !== 1'b1 || ram_rd(AW'(219)) !== 12'h313) begin
            n_fail++; $display("FAIL contention_end got acc=%0d lvl=%0d rdy=%b ram219=%h exp 20/0/1/313",
                               acc, bus.fifo_level, bus.wr_ready, ram_rd(AW'(219)));
        end
        tick();
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.rd_req   = (c < 3);
            bus.rd_addr  = AW'(c);
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(30 + c);
            bus.wr_data  = DW'(12'h050 + c);
            @(negedge pixel_clk);
            if (c >= 3) begin
                n_chk++;
                if (bus.fifo_level !== 5'd3 || bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(30 + c - 3) ||
                    bus.mem_wdata !== DW'(12'h050 + c - 3)) begin
                    n_fail++; $display("FAIL push_pop c=%0d got lvl=%0d we=%b addr=%0d data=%h exp 3/1/%0d/%h",
                                       c, bus.fifo_level, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                       30 + c - 3, 12'h050 + c - 3);
                end
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        @(negedge pixel_clk);
        n_chk++;
        if (bus.fifo_level !== '0) begin
            n_fail++; $display("FAIL push_pop_drain got lvl=%0d exp 0", bus.fifo_level);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            bus.rd_req   = 1'b1;
            bus.rd_addr  = AW'(c);
            bus.wr_valid = (c < 8);
            bus.wr_addr  = AW'(400 + c);
            bus.wr_data  = DW'(12'h600 + c);
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge pixel_clk);
        n_chk++;
        if (bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_we got %b exp 0", bus.mem_we);
        end
        tick();
        rst = 1'b0;
        @(negedge pixel_clk);
        n_chk++;
        if (bus.fifo_level !== '0 || bus.rd_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.starve_cnt !== '0) begin
            n_fail++; $display("FAIL reset_mid_state got lvl=%0d vld=%b en=%b st=%0d exp 0/0/0/0",
                               bus.fifo_level, bus.rd_valid, bus.mem_en, bus.starve_cnt);
        end
        for (int c = 0; c < 10; c++) tick();
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (ram.exists(400 + k)) begin
                n_fail++; $display("FAIL reset_mid_leak addr=%0d got written=1 exp 0", 400 + k);
            end
        end
    endtask

    task automatic test_saturation();
        rst2 = 1'b1;
        bus2.rd_req = 1'b0; bus2.rd_addr = '0; bus2.wr_valid = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        tick();
        tick();
        rst2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus2.rd_req   = 1'b1;
            bus2.wr_valid = (c == 0);
            bus2.wr_addr  = AW'(7);
            bus2.wr_data  = DW'(12'h777);
            @(negedge pixel_clk);
            if (c == 10) begin
                n_chk++;
                if (bus2.starve_cnt !== 4'd9) begin
                    n_fail++; $display("FAIL starve_count got %0d exp 9", bus2.starve_cnt);
                end
            end
            tick();
        end
        bus2.rd_req = 1'b0;
        bus2.wr_valid = 1'b0;
        @(negedge pixel_clk);
        n_chk++;
        if (bus2.starve_cnt !== 4'd15 || bus2.fifo_level !== 5'd1) begin
            n_fail++; $display("FAIL starve_sat got st=%0d lvl=%0d exp 15/1", bus2.starve_cnt, bus2.fifo_level);
        end
        tick();
        tick();
        @(negedge pixel_clk);
        n_chk++;
        if (bus2.starve_cnt !== 4'd15 || bus2.fifo_level !== '0) begin
            n_fail++; $display("FAIL starve_hold got st=%0d lvl=%0d exp 15/0", bus2.starve_cnt, bus2.fifo_level);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        idle_inputs();
        bus2.rd_req = 1'b0; bus2.rd_addr = '0; bus2.wr_valid = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        for (int a = 0; a < 64; a++) ram[a] = DW'(12'h100 + a);
        test_reset();
        test_read_stream();
        test_write_only();
        test_contention();
        test_push_pop();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
